// File: rtl/imem_responder.sv
// Instruction-memory responder: dual-lane reads answered after a fixed LATENCY,
// with flush-on-redirect and a preload write port.
module imem_responder #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           imem_ren,
    input  logic [XLEN-1:0]                imem_addr0,
    input  logic [XLEN-1:0]                imem_addr1,
    input  logic                           flush,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    output logic                           imem_valid,
    output logic [XLEN-1:0]                imem_rdata0,
    output logic [XLEN-1:0]                imem_rdata1,
    output logic [XLEN-1:0]                imem_pc [1:0],
    output logic [1:0]                     imem_err,
    output logic [3:0]                     imem_inflight
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    if (LATENCY < 1 || LATENCY > 8) begin : g_latency_check
        $error("imem_responder: LATENCY must be in 1..8");
    end

    typedef struct packed {
        logic [XLEN-1:0] addr0;
        logic [XLEN-1:0] addr1;
        logic [XLEN-1:0] data0;
        logic [XLEN-1:0] data1;
        logic [1:0]      err;
    } stage_t;

    logic [31:0]        mem [DEPTH_WORDS];
    stage_t             stg_q [LATENCY];
    stage_t             stg_d [LATENCY];
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [3:0]         inflight_q, inflight_d;
    stage_t             snap;

    function automatic logic lane_err(input logic [XLEN-1:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[XLEN-1:2]} >= XLEN'(DEPTH_WORDS));
    endfunction

    // Snapshot of the request taken at the accepting edge; erroring lanes read as zero.
    always_comb begin
        snap.addr0 = imem_addr0;
        snap.addr1 = imem_addr1;
        snap.err   = {lane_err(imem_addr1), lane_err(imem_addr0)};
        snap.data0 = snap.err[0] ? '0 : XLEN'(mem[imem_addr0[AW+1:2]]);
        snap.data1 = snap.err[1] ? '0 : XLEN'(mem[imem_addr1[AW+1:2]]);
    end

    // Payload only moves with a valid bit, so the last stage keeps the last response.
    always_comb begin
        stg_d    = stg_q;
        vld_d    = '0;
        vld_d[0] = imem_ren;
        if (imem_ren) begin
            stg_d[0] = snap;
        end
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_d[i] = vld_q[i-1] & ~flush;
            if (vld_d[i]) begin
                stg_d[i] = stg_q[i-1];
            end
        end
        inflight_d = '0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            inflight_d = inflight_d + 4'(vld_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q      <= '0;
            inflight_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            stg_q      <= stg_d;
        end
    end

    // Array is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        imem_valid    = vld_q[LATENCY-1];
        imem_rdata0   = stg_q[LATENCY-1].data0;
        imem_rdata1   = stg_q[LATENCY-1].data1;
        imem_pc[0]    = stg_q[LATENCY-1].addr0;
        imem_pc[1]    = stg_q[LATENCY-1].addr1;
        imem_err      = stg_q[LATENCY-1].err;
        imem_inflight = inflight_q;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder that serves the fetch stage's dual-lane read requests (imem_ren, imem_addr0/1). It returns imem_rdata0/1, the matching imem_pc pair and imem_valid after a fixed, parameterised latency. It replaces ad-hoc bench memory models, guarantees that returned PCs match the data of the same request, and supports flush on redirect plus a preload write port for initialisation.

Parameters:
XLEN, 32, address/data width
DEPTH_WORDS, 1024, memory depth in 32-bit words; word index is addr[31:2]
LATENCY, 1, cycles from request acceptance to response; legal range 1..8, out-of-range values are caught by an elaboration assertion

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
imem_ren  input  1  read request; both lanes issued together
imem_addr0  input  XLEN  lane-0 byte address
imem_addr1  input  XLEN  lane-1 byte address
flush  input  1  discard all in-flight responses (redirect)
load_en  input  1  preload write enable
load_addr  input  $clog2(DEPTH_WORDS)  preload word index
load_data  input  32  preload data
imem_valid  output  1  response valid
imem_rdata0  output  XLEN  lane-0 instruction
imem_rdata1  output  XLEN  lane-1 instruction
imem_pc  output  XLEN x 2 (unpacked [1:0])  byte addresses of the request being answered
imem_err  output  2  per-lane error: misaligned or out-of-range
imem_inflight  output  4  number of accepted requests not yet responded

Behaviour:
- Reset (async): imem_valid=0, imem_rdata0/1=0, imem_pc[0]/[1]=0, imem_err=0, imem_inflight=0. All pipeline valid bits clear. Memory array contents are NOT reset.
- No backpressure. A request is accepted on every posedge where imem_ren=1.
- Read snapshot is taken at the accepting edge. Data, addresses and err flags for that request enter pipeline stage 0.
- The pipeline is a LATENCY-deep shift register of {valid, addr0, addr1, data0, data1, err}, advancing every cycle.
- A request accepted at edge N is presented on outputs after edge N+LATENCY-1 and held for exactly one cycle. With LATENCY=1 it is visible in the cycle right after the accepting edge.
- Back-to-back requests give back-to-back responses in request order.
- imem_pc[i] always equals the imem_addr_i of the request whose data is on imem_rdata_i.
- When imem_valid=0, imem_rdata/imem_pc/imem_err hold their last values. Only imem_valid is meaningful.
- Per-lane error conditions:
  - addr[1:0] != 0: data 32'h0, err bit set.
  - addr[31:2] >= DEPTH_WORDS: data 32'h0, err bit set.
  - Both conditions true: single err bit, data 0.
  - An error on one lane does not affect the other lane.
- Flush:
  - At the edge where flush=1, all in-flight pipeline valid bits clear, including a response that would present after that edge.
  - A request with imem_ren=1 in the same cycle as flush is accepted. It is the redirected fetch.
  - After flush, imem_inflight = 1 if a request was accepted that cycle, else 0.
- Preload:
  - load_en writes mem[load_addr] at posedge.
  - Read and load to the same word in the same cycle: the read snapshot returns the OLD value. The new value is visible to requests accepted on later edges.
  - load_en and imem_ren may be active simultaneously.
- imem_inflight = count of valid pipeline stages not yet presented, saturating at LATENCY. It increments on accept, decrements on present, and is unchanged on simultaneous accept+present.
- Reset asserted mid-operation: all in-flight requests are lost with no response. imem_valid drops immediately (async).

Test Plan:
- LATENCY=1, preload mem[0]=0x00221820, mem[1]=0x20850064; request addr0=0x0, addr1=0x4 -> one cycle later imem_valid=1, rdata0=0x00221820, rdata1=0x20850064, imem_pc={0x4,0x0}, err=00.
- LATENCY=3, imem_ren high for 4 cycles at 0x0/0x4, 0x8/0xC, 0x10/0x14, 0x18/0x1C -> 4 consecutive valid responses starting 3 cycles after the first accept, in order, each PC pair matching its data. imem_inflight reaches 3.
- LATENCY=3, two requests in flight, then flush together with a new request at 0x40/0x44 -> only 0x40/0x44 responds, 3 cycles after the flush edge. No response carries PC 0x0 or 0x8.
- Request addr0=0x2, addr1=0x1000 (DEPTH_WORDS=1024) -> imem_err=11, both data 0. Request addr0=0x8, addr1=0x1000 -> err=10, rdata0=mem[2].
- Same cycle: load_en writes mem[5]=0xDEADBEEF (old value 0x11111111) and a request reads 0x14 -> response 0x11111111. The next request to 0x14 -> 0xDEADBEEF.
- LATENCY=2, assert reset one cycle after a request -> imem_valid stays 0, imem_inflight=0. After reset release the memory still holds preloaded contents.
